// File: rtl/display_sequencer.sv
// Display sequencer for a number-guessing game: turns the game state code into
// registered digit codes, an LED bar, and timed HI/LO hint and result-blink phases.
//
// mode      | meaning
// ----------+---------------------------------------------------------------
// M_IDLE    | all digits and LEDs dark (0000)
// M_PLAY    | play banner on digits 0..3, LED bar retained
// M_HINT_LO | "LO" hint, hold timer running, returns to M_PLAY at terminal count
// M_HINT_HI | "HI" hint, hold timer running, returns to M_PLAY at terminal count
// M_RESULT  | count/target digits blinking on/off, LED bar frozen at entry value
module display_sequencer #(
    parameter int NUM_DIGITS   = 4,
    parameter int LED_W        = 10,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic [2:0]              state,
    input  logic                    neg,
    input  logic [3:0]              rdm0,
    input  logic [3:0]              rdm1,
    input  logic [3:0]              count0,
    input  logic [3:0]              count1,
    output logic [4*NUM_DIGITS-1:0] OUT,
    output logic [LED_W-1:0]        led,
    output logic                    hint_active
);

    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [2:0] {
        M_IDLE    = 3'd0,
        M_PLAY    = 3'd1,
        M_HINT_LO = 3'd2,
        M_HINT_HI = 3'd3,
        M_RESULT  = 3'd4
    } mode_t;

    mode_t                   mode_q, mode_d;
    logic [2:0]              state_q;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [BLINK_W-1:0]      blink_q, blink_d;
    logic                    phase_q, phase_d;
    logic [4*NUM_DIGITS-1:0] out_q, out_d;
    logic [LED_W-1:0]        led_q, led_d;
    logic                    hint_q, hint_d;
    logic                    change;
    logic [15:0]             low_d;
    logic [3:0]              blank_d;

    assign change = (state != state_q);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            mode_q  <= M_IDLE;
            state_q <= 3'd0;
            hold_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            out_q   <= '0;
            led_q   <= '0;
            hint_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            state_q <= state;
            hold_q  <= hold_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            out_q   <= out_d;
            led_q   <= led_d;
            hint_q  <= hint_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        hold_d  = hold_q;
        blink_d = blink_q;
        phase_d = phase_q;
        led_d   = led_q;

        // Codes 5..7 fall through to the timer branch so holds and blinks keep running.
        if (change && (state <= 3'd4)) begin
            case (state)
                3'd0: mode_d = M_IDLE;
                3'd1: mode_d = M_PLAY;
                3'd2: begin
                    mode_d = M_HINT_LO;
                    hold_d = HOLD_LOAD;
                end
                3'd3: begin
                    mode_d = M_HINT_HI;
                    hold_d = HOLD_LOAD;
                end
                default: begin
                    mode_d       = M_RESULT;
                    blink_d      = BLINK_LOAD;
                    phase_d      = 1'b1;
                    led_d        = '0;
                    led_d[9:0]   = {neg, 1'b0, rdm1, rdm0};
                end
            endcase
        end else begin
            case (mode_q)
                M_HINT_LO, M_HINT_HI: begin
                    if (hold_q == '0) mode_d = M_PLAY;
                    else              hold_d = hold_q - HOLD_W'(1);
                end
                M_RESULT: begin
                    if (blink_q == '0) begin
                        phase_d = ~phase_q;
                        blink_d = BLINK_LOAD;
                    end else begin
                        blink_d = blink_q - BLINK_W'(1);
                    end
                end
                default: ;
            endcase
        end

        if (mode_d == M_IDLE) led_d = '0;
        hint_d = (mode_d == M_HINT_LO) || (mode_d == M_HINT_HI);
    end

    always_comb begin
        blank_d = (mode_d == M_IDLE) ? 4'h0 : 4'hF;
        case (mode_d)
            M_PLAY:    low_d = 16'hABCD;
            M_HINT_LO: low_d = 16'hFB0F;
            M_HINT_HI: low_d = 16'hFE1F;
            M_RESULT:  low_d = phase_d ? {rdm1, rdm0, count1, count0} : 16'hFFFF;
            default:   low_d = 16'h0000;
        endcase
        out_d = '0;
        for (int i = 4; i < NUM_DIGITS; i++) out_d[4*i +: 4] = blank_d;
        out_d[15:0] = low_d;
    end

    assign OUT         = out_q;
    assign led         = led_q;
    assign hint_active = hint_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Scenario bench for display_sequencer: each task queues per-cycle stimulus with
// its expected registered outputs, then replays the queue against the DUT.
module tb_display_sequencer;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [2:0]  state;
    logic        neg;
    logic [3:0]  rdm0, rdm1, count0, count1;
    logic [23:0] OUT;
    logic [11:0] led;
    logic        hint_active;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rn;
        logic [2:0]  st;
        logic        ng;
        logic [3:0]  r0, r1, c0, c1;
        logic [23:0] out;
        logic [11:0] led;
        logic        ha;
    } step_t;

    step_t sbq[$];

    logic       cur_neg;
    logic [3:0] cur_r0, cur_r1, cur_c0, cur_c1;

    display_sequencer #(
        .NUM_DIGITS(6), .LED_W(12), .HOLD_CYCLES(6), .BLINK_CYCLES(4)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .state(state), .neg(neg),
        .rdm0(rdm0), .rdm1(rdm1), .count0(count0), .count1(count1),
        .OUT(OUT), .led(led), .hint_active(hint_active)
    );

    always #5 Clock = ~Clock;

    function automatic void add(int n, logic rn, logic [2:0] st,
                                logic [23:0] o, logic [11:0] l, logic h);
        step_t s;
        s.rn = rn; s.st = st; s.ng = cur_neg;
        s.r0 = cur_r0; s.r1 = cur_r1; s.c0 = cur_c0; s.c1 = cur_c1;
        s.out = o; s.led = l; s.ha = h;
        for (int k = 0; k < n; k++) sbq.push_back(s);
    endfunction

    task automatic test_reset();
        step_t s;
        int cyc = 0;
        add(2, 1'b0, 3'd3, 24'h000000, 12'h000, 1'b0);
        add(2, 1'b1, 3'd0, 24'h000000, 12'h000, 1'b0);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            Resetn = s.rn; state = s.st; neg = s.ng;
            rdm0 = s.r0; rdm1 = s.r1; count0 = s.c0; count1 = s.c1;
            @(posedge Clock); #1;
            checks++;
            if (OUT !== s.out || led !== s.led || hint_active !== s.ha) begin
                errors++;
                $display("FAIL reset cyc %0d: OUT=%h led=%h ha=%b expected OUT=%h led=%h ha=%b",
                         cyc, OUT, led, hint_active, s.out, s.led, s.ha);
            end
            cyc++;
        end
    endtask

    task automatic test_play_and_hints();
        step_t s;
        int cyc = 0;
        add(2, 1'b1, 3'd1, 24'hFFABCD, 12'h000, 1'b0);
        add(6, 1'b1, 3'd2, 24'hFFFB0F, 12'h000, 1'b1);
        add(2, 1'b1, 3'd2, 24'hFFABCD, 12'h000, 1'b0);
        add(1, 1'b1, 3'd5, 24'hFFABCD, 12'h000, 1'b0);
        add(3, 1'b1, 3'd3, 24'hFFFE1F, 12'h000, 1'b1);
        add(2, 1'b1, 3'd1, 24'hFFABCD, 12'h000, 1'b0);
        add(3, 1'b1, 3'd2, 24'hFFFB0F, 12'h000, 1'b1);
        add(6, 1'b1, 3'd3, 24'hFFFE1F, 12'h000, 1'b1);
        add(1, 1'b1, 3'd3, 24'hFFABCD, 12'h000, 1'b0);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            Resetn = s.rn; state = s.st; neg = s.ng;
            rdm0 = s.r0; rdm1 = s.r1; count0 = s.c0; count1 = s.c1;
            @(posedge Clock); #1;
            checks++;
            if (OUT !== s.out || led !== s.led || hint_active !== s.ha) begin
                errors++;
                $display("FAIL hints cyc %0d: OUT=%h led=%h ha=%b expected OUT=%h led=%h ha=%b",
                         cyc, OUT, led, hint_active, s.out, s.led, s.ha);
            end
            cyc++;
        end
    endtask

    task automatic test_result_blink();
        step_t s;
        int cyc = 0;
        cur_neg = 1'b1; cur_c0 = 4'd3; cur_c1 = 4'd0; cur_r0 = 4'd7; cur_r1 = 4'd2;
        add(4, 1'b1, 3'd4, 24'hFF2703, 12'h227, 1'b0);
        add(4, 1'b1, 3'd4, 24'hFFFFFF, 12'h227, 1'b0);
        cur_neg = 1'b0;
        add(2, 1'b1, 3'd4, 24'hFF2703, 12'h227, 1'b0);
        add(2, 1'b1, 3'd6, 24'hFF2703, 12'h227, 1'b0);
        add(4, 1'b1, 3'd6, 24'hFFFFFF, 12'h227, 1'b0);
        add(1, 1'b1, 3'd6, 24'hFF2703, 12'h227, 1'b0);
        add(2, 1'b1, 3'd0, 24'h000000, 12'h000, 1'b0);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            Resetn = s.rn; state = s.st; neg = s.ng;
            rdm0 = s.r0; rdm1 = s.r1; count0 = s.c0; count1 = s.c1;
            @(posedge Clock); #1;
            checks++;
            if (OUT !== s.out || led !== s.led || hint_active !== s.ha) begin
                errors++;
                $display("FAIL result cyc %0d: OUT=%h led=%h ha=%b expected OUT=%h led=%h ha=%b",
                         cyc, OUT, led, hint_active, s.out, s.led, s.ha);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        int cyc = 0;
        add(1, 1'b1, 3'd1, 24'hFFABCD, 12'h000, 1'b0);
        cur_neg = 1'b0; cur_c0 = 4'd1; cur_c1 = 4'd2; cur_r0 = 4'd9; cur_r1 = 4'd5;
        add(2, 1'b1, 3'd4, 24'hFF5921, 12'h059, 1'b0);
        add(2, 1'b1, 3'd1, 24'hFFABCD, 12'h059, 1'b0);
        add(1, 1'b1, 3'd2, 24'hFFFB0F, 12'h059, 1'b1);
        add(1, 1'b1, 3'd0, 24'h000000, 12'h000, 1'b0);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            Resetn = s.rn; state = s.st; neg = s.ng;
            rdm0 = s.r0; rdm1 = s.r1; count0 = s.c0; count1 = s.c1;
            @(posedge Clock); #1;
            checks++;
            if (OUT !== s.out || led !== s.led || hint_active !== s.ha) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: OUT=%h led=%h ha=%b expected OUT=%h led=%h ha=%b",
                         cyc, OUT, led, hint_active, s.out, s.led, s.ha);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid_hold();
        step_t s;
        int cyc = 0;
        add(2, 1'b1, 3'd2, 24'hFFFB0F, 12'h000, 1'b1);
        add(1, 1'b0, 3'd2, 24'h000000, 12'h000, 1'b0);
        add(6, 1'b1, 3'd2, 24'hFFFB0F, 12'h000, 1'b1);
        add(1, 1'b1, 3'd2, 24'hFFABCD, 12'h000, 1'b0);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            Resetn = s.rn; state = s.st; neg = s.ng;
            rdm0 = s.r0; rdm1 = s.r1; count0 = s.c0; count1 = s.c1;
            @(posedge Clock); #1;
            checks++;
            if (OUT !== s.out || led !== s.led || hint_active !== s.ha) begin
                errors++;
                $display("FAIL reset_mid_hold cyc %0d: OUT=%h led=%h ha=%b expected OUT=%h led=%h ha=%b",
                         cyc, OUT, led, hint_active, s.out, s.led, s.ha);
            end
            cyc++;
        end
    endtask

    initial begin
        Resetn = 1'b0; state = 3'd0; neg = 1'b0;
        rdm0 = 4'd0; rdm1 = 4'd0; count0 = 4'd0; count1 = 4'd0;
        cur_neg = 1'b0; cur_r0 = 4'd0; cur_r1 = 4'd0; cur_c0 = 4'd0; cur_c1 = 4'd0;
        test_reset();
        test_play_and_hints();
        test_result_blink();
        test_back_to_back();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
